// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants shared with ALU control, datapath width and
//               the alu_core FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_width = 32;

    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_mul = 4'b0011;
    localparam logic [3:0] c_op_div = 4'b0100;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative unsigned 32x32 shift-add multiplier and restoring
//               divider, one bit per cycle, 32 iterations per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_div,
    input  logic [c_width-1:0]   i_a,
    input  logic [c_width-1:0]   i_b,
    output logic                 o_done,
    output logic [c_width-1:0]   o_lo,
    output logic [c_width-1:0]   o_hi
);

    logic                 r_run;
    logic                 r_div;
    logic                 r_done;
    logic [4:0]           r_cnt;
    logic [c_width-1:0]   r_acc;
    logic [c_width-1:0]   r_mq;
    logic [c_width-1:0]   r_b;

    logic                 w_div;
    logic [c_width-1:0]   w_acc_in;
    logic [c_width-1:0]   w_mq_in;
    logic [c_width-1:0]   w_b;
    logic [c_width:0]     w_sum;
    logic [c_width:0]     w_shift;
    logic [c_width:0]     w_diff;
    logic [c_width-1:0]   w_acc_nxt;
    logic [c_width-1:0]   w_mq_nxt;

    // The first iteration runs on the start edge straight from the inputs,
    // so 32 iterations complete on edges 0..31 of the operation.
    always_comb begin
        w_div    = r_run ? r_div : i_div;
        w_acc_in = r_run ? r_acc : '0;
        w_mq_in  = r_run ? r_mq  : i_a;
        w_b      = r_run ? r_b   : i_b;
        w_sum    = {1'b0, w_acc_in} + (w_mq_in[0] ? {1'b0, w_b} : '0);
        w_shift  = {w_acc_in, w_mq_in[c_width-1]};
        w_diff   = w_shift - {1'b0, w_b};
        if (w_div) begin
            if (w_diff[c_width]) begin
                w_acc_nxt = w_shift[c_width-1:0];
                w_mq_nxt  = {w_mq_in[c_width-2:0], 1'b0};
            end else begin
                w_acc_nxt = w_diff[c_width-1:0];
                w_mq_nxt  = {w_mq_in[c_width-2:0], 1'b1};
            end
        end else begin
            w_acc_nxt = w_sum[c_width:1];
            w_mq_nxt  = {w_sum[0], w_mq_in[c_width-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run  <= 1'b0;
            r_div  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 5'd0;
            r_acc  <= '0;
            r_mq   <= '0;
            r_b    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_run) begin
                r_acc <= w_acc_nxt;
                r_mq  <= w_mq_nxt;
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (i_start) begin
                r_acc <= w_acc_nxt;
                r_mq  <= w_mq_nxt;
                r_b   <= i_b;
                r_div <= i_div;
                r_cnt <= 5'd1;
                r_run <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_lo   = r_mq;
    assign o_hi   = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Registered ALU with start/busy/done handshake; logic and
//               add/sub/slt ops complete in one cycle, MUL/DIV iterate.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           ALUControlInput,
    input  logic [c_width-1:0]   A,
    input  logic [c_width-1:0]   B,
    output logic [c_width-1:0]   ALUResult,
    output logic [c_width-1:0]   Hi,
    output logic                 Zero,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t               r_state;
    logic [c_width-1:0]   r_result;
    logic [c_width-1:0]   r_hi;
    logic                 r_zero;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic [c_width-1:0]   w_single;
    logic                 w_illegal;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_div0;
    logic                 w_seq_start;
    logic                 w_seq_done;
    logic [c_width-1:0]   w_seq_lo;
    logic [c_width-1:0]   w_seq_hi;

    always_comb begin
        w_single  = '0;
        w_illegal = 1'b0;
        case (ALUControlInput)
            c_op_and: w_single = A & B;
            c_op_or:  w_single = A | B;
            c_op_add: w_single = A + B;
            c_op_sub: w_single = A - B;
            c_op_slt: w_single = {{(c_width-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  w_illegal = 1'b1;
        endcase
    end

    assign w_is_mul    = (ALUControlInput == c_op_mul);
    assign w_is_div    = (ALUControlInput == c_op_div);
    assign w_div0      = (B == '0);
    assign w_seq_start = (r_state == ST_IDLE) && start && (w_is_mul || (w_is_div && !w_div0));

    alu_muldiv_seq u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_seq_start),
        .i_div   (w_is_div),
        .i_a     (A),
        .i_b     (B),
        .o_done  (w_seq_done),
        .o_lo    (w_seq_lo),
        .o_hi    (w_seq_hi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else if (w_is_div && !w_div0) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            if (w_is_div) begin
                                // Divide by zero: all-ones quotient, dividend as remainder.
                                r_result <= '1;
                                r_hi     <= A;
                                r_zero   <= 1'b0;
                                r_err    <= 1'b1;
                            end else begin
                                r_result <= w_single;
                                r_hi     <= '0;
                                r_zero   <= (w_single == '0);
                                r_err    <= w_illegal;
                            end
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_seq_done) begin
                        r_result <= w_seq_lo;
                        r_hi     <= w_seq_hi;
                        r_zero   <= (w_seq_lo == '0);
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ALUResult = r_result;
    assign Hi        = r_hi;
    assign Zero      = r_zero;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_core
// Description : Directed self-checking bench for alu_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ALUResult;
    logic [31:0] Hi;
    logic        Zero;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int lat;
    bit seen_done;

    alu_core dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .ALUControlInput (op),
        .A               (a),
        .B               (b),
        .ALUResult       (ALUResult),
        .Hi              (Hi),
        .Zero            (Zero),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op from an IDLE cycle and wait (bounded) for done; lat counts
    // edges from the accepting edge (1 = done in the following cycle).
    task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit disturb);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (disturb && lat == 10) begin
                chk("busy_mid_op", {31'd0, busy}, 32'd1);
                start = 1'b1; a = 32'd3; b = 32'd3; op = 4'b0010;
            end
            if (disturb && lat == 11) start = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_hi",     Hi,        32'd0);
        chk("rst_zero",   {31'd0, Zero}, 32'd1);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_err",    {31'd0, err},  32'd0);
        reset_n = 1'b1;

        run(4'b0010, 32'd7, 32'd5, 1'b0);
        chk("add_lat",    lat,       32'd1);
        chk("add_result", ALUResult, 32'd12);
        chk("add_hi",     Hi,        32'd0);
        chk("add_zero",   {31'd0, Zero}, 32'd0);
        chk("add_err",    {31'd0, err},  32'd0);
        idle_cycle();
        chk("add_busy_cleared", {31'd0, busy}, 32'd0);
        chk("add_done_pulse",   {31'd0, done}, 32'd0);
        chk("add_hold",   ALUResult, 32'd12);

        run(4'b0110, 32'd9, 32'd9, 1'b0);
        chk("sub_lat",    lat,       32'd1);
        chk("sub_result", ALUResult, 32'd0);
        chk("sub_zero",   {31'd0, Zero}, 32'd1);
        idle_cycle();

        run(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("slt_neg_result", ALUResult, 32'd1);
        chk("slt_neg_zero",   {31'd0, Zero}, 32'd0);
        idle_cycle();
        run(4'b0111, 32'd1, 32'hFFFF_FFFF, 1'b0);
        chk("slt_pos_result", ALUResult, 32'd0);
        idle_cycle();

        run(4'b0000, 32'hF0F0_00FF, 32'hFF00_0F0F, 1'b0);
        chk("and_result", ALUResult, 32'hF000_000F);
        idle_cycle();
        run(4'b0001, 32'hF0F0_00FF, 32'hFF00_0F0F, 1'b0);
        chk("or_result",  ALUResult, 32'hFFF0_0FFF);
        idle_cycle();

        run(4'b0011, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("mul_lat",    lat,       32'd33);
        chk("mul_result", ALUResult, 32'hFFFF_FFFE);
        chk("mul_hi",     Hi,        32'd1);
        chk("mul_err",    {31'd0, err}, 32'd0);
        idle_cycle();
        chk("mul_ignored_start", {31'd0, busy}, 32'd0);

        run(4'b0011, 32'd100000, 32'd100000, 1'b0);
        chk("mul2_result", ALUResult, 32'h540B_E400);
        chk("mul2_hi",     Hi,        32'd2);
        idle_cycle();

        run(4'b0100, 32'd100, 32'd7, 1'b0);
        chk("div_lat",    lat,       32'd33);
        chk("div_result", ALUResult, 32'd14);
        chk("div_hi",     Hi,        32'd2);
        chk("div_err",    {31'd0, err}, 32'd0);
        idle_cycle();

        run(4'b0100, 32'd5, 32'd0, 1'b0);
        chk("div0_lat",    lat,       32'd1);
        chk("div0_result", ALUResult, 32'hFFFF_FFFF);
        chk("div0_hi",     Hi,        32'd5);
        chk("div0_err",    {31'd0, err},  32'd1);
        chk("div0_zero",   {31'd0, Zero}, 32'd0);
        idle_cycle();

        run(4'b1111, 32'd3, 32'd4, 1'b0);
        chk("ill_lat",    lat,       32'd1);
        chk("ill_result", ALUResult, 32'd0);
        chk("ill_hi",     Hi,        32'd0);
        chk("ill_zero",   {31'd0, Zero}, 32'd1);
        chk("ill_err",    {31'd0, err},  32'd1);
        idle_cycle();

        run(4'b0010, 32'h10, 32'h20, 1'b0);
        chk("b2b_lat",    lat,       32'd1);
        chk("b2b_result", ALUResult, 32'h30);
        chk("b2b_err",    {31'd0, err}, 32'd0);
        idle_cycle();

        op = 4'b0011; a = 32'h1234; b = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_result", ALUResult, 32'd0);
        chk("abort_hi",     Hi,        32'd0);
        chk("abort_zero",   {31'd0, Zero}, 32'd1);
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_err",    {31'd0, err},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);

        run(4'b0010, 32'd1, 32'd1, 1'b0);
        chk("post_rst_lat",    lat,       32'd1);
        chk("post_rst_result", ALUResult, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request to launch an operation; sampled only while busy=0.
REQ-004 SHALL have port ALUControlInput, input, 4, operation code from ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 MUL, 0100 DIV.
REQ-005 SHALL have ports A and B, input, 32 each, operands captured on the accepting edge.
REQ-006 SHALL have port ALUResult, output, 32, registered result: low word for MUL, quotient for DIV.
REQ-007 SHALL have port Hi, output, 32, registered high word for MUL, remainder for DIV, 0 for all other ops.
REQ-008 SHALL have port Zero, output, 1, registered flag, 1 iff ALUResult==0.
REQ-009 SHALL have port busy, output, 1, high from the accepting edge until done is asserted.
REQ-010 SHALL have port done, output, 1, single-cycle pulse marking valid ALUResult/Hi/Zero.
REQ-011 SHALL have port err, output, 1, registered with done: illegal opcode or divide by zero.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 IDLE with start=1 SHALL latch A, B and the opcode, set busy=1 and select the next state: MUL for 0011, DIV for 0100, DONE otherwise.
REQ-014 For single-cycle ops the result SHALL be written on the accepting edge; done=1 in the following cycle (latency 1).
REQ-015 ADD/SUB SHALL be 32-bit modulo; overflow is ignored.
REQ-016 SLT SHALL compare signed two's complement and give 32'd1 or 32'd0.
REQ-017 MUL SHALL be unsigned 32x32->64 iterative shift-add, one bit per cycle, with a 5-bit counter.
REQ-018 DIV SHALL be unsigned restoring division, one quotient bit per cycle, with a 5-bit counter.
REQ-019 MUL/DIV SHALL go to DONE after exactly 32 iterations; done is asserted 33 cycles after the accepting edge.
REQ-020 DIV with B==0 SHALL skip iteration and go straight to DONE with ALUResult=32'hFFFFFFFF, Hi=A, err=1 (latency 1).
REQ-021 An illegal opcode SHALL give ALUResult=0, Hi=0, Zero=1, err=1, latency 1.
REQ-022 DONE SHALL assert done for one cycle, clear busy and return to IDLE.
REQ-023 start SHALL be ignored while busy=1; a start in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-024 ALUResult, Hi, Zero and err SHALL hold their values until the next done.
REQ-025 Operand or opcode changes after the accepting edge SHALL NOT affect the operation in flight.

Reset
REQ-026 reset_n=0 SHALL, asynchronously, force state IDLE, counter 0, internal operand and accumulator registers 0, and ALUResult=0, Hi=0, Zero=1, busy=0, done=0, err=0.
REQ-027 Reset asserted during MUL/DIV SHALL abort the operation with no done pulse.
REQ-028 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit opcode constants (shared with ALU control) and the FSM state enum.
REQ-030 The iterative MUL/DIV datapath SHALL be the sub-module alu_muldiv_seq, with its own start/done handshake.
REQ-031 Single-cycle ops SHALL stay inline in alu_core.

Verification
REQ-032 ADD A=7, B=5, start held one cycle -> next cycle done=1, ALUResult=12, Hi=0, Zero=0, err=0.
REQ-033 SUB A=9, B=9 -> done after 1 cycle, ALUResult=0, Zero=1; SLT A=32'hFFFFFFFF, B=1 -> ALUResult=1.
REQ-034 MUL A=32'hFFFFFFFF, B=2 -> busy for 33 cycles, then done with Hi=1, ALUResult=32'hFFFFFFFE; a start pulsed mid-operation is ignored.
REQ-035 DIV A=100, B=7 -> done at cycle 33, ALUResult=14, Hi=2; DIV A=5, B=0 -> done at cycle 1, ALUResult=32'hFFFFFFFF, Hi=5, err=1.
REQ-036 Start MUL, assert reset_n=0 at cycle 10 -> outputs go to reset values immediately with no done; after release, ADD 1+1 -> 2.
REQ-037 Opcode 4'b1111 -> done after 1 cycle, ALUResult=0, err=1; back-to-back start in the cycle after done is accepted.
